// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   - DefaultAddrW : default RAM word-address width.
//   - loader_state_e : 4-bit FSM state encoding.
//   - takes_byte() : states in which a stream byte may be accepted.
//   - is_busy()    : states that belong to an active load.
package loader_pkg;

    localparam int unsigned DefaultAddrW = 8;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StLenHi  = 4'd1,
        StLenLo  = 4'd2,
        StDataHi = 4'd3,
        StDataLo = 4'd4,
        StWrite  = 4'd5,
        StChk    = 4'd6,
        StDone   = 4'd7,
        StErr    = 4'd8
    } loader_state_e;

    function automatic logic takes_byte(loader_state_e st);
        return st inside {StLenHi, StLenLo, StDataHi, StDataLo, StChk};
    endfunction

    function automatic logic is_busy(loader_state_e st);
        return st inside {StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StChk};
    endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: fills the CPU instruction RAM from a byte stream and holds the
// CPU in reset until a complete program is loaded.
// Stream: LEN_HI, LEN_LO (word count N), N x {hi, lo}, [checksum byte].
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes.
// Ports:
//   clk_i          system clock (rising edge)
//   rst_ni         asynchronous active-low reset
//   load_req_i     starts a load when sampled in IDLE, DONE or ERR
//   byte_in_i      stream byte
//   byte_valid_i   byte_in_i valid
//   byte_ready_o   loader accepts a byte this cycle
//   ram_we_o       one-cycle RAM write strobe
//   ram_addr_o     RAM word address
//   ram_wdata_o    RAM write data (big-endian word)
//   cpu_hold_o     CPU held in reset
//   busy_o         load in progress
//   done_o         load succeeded (sticky until next load)
//   err_o          load failed (sticky until next load)
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_req_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [15:0]       ram_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e FinishSt = StChk;
`else
    localparam loader_state_e FinishSt = StDone;
`endif

    localparam logic [31:0] MaxWords = 32'd1 << ADDR_W;

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q;
    // One extra bit so that a full 2^ADDR_W-word program is representable.
    logic [ADDR_W:0]   idx_q;
    logic [7:0]        hi_q;
    logic              byte_ready_q, ram_we_q, cpu_hold_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [15:0]       ram_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    logic        accept;
    logic [15:0] len_next;
    logic        last_word;
    logic        start;

    assign accept    = byte_valid_i & byte_ready_q;
    assign len_next  = {len_q[15:8], byte_in_i};
    assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);
    assign start     = (state_q inside {StIdle, StDone, StErr}) && load_req_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: if (load_req_i) state_d = StLenHi;
            StLenHi:  if (accept) state_d = StLenLo;
            StLenLo: begin
                if (accept) begin
                    if (len_next == 16'd0)                 state_d = FinishSt;
                    else if (32'(len_next) > MaxWords)     state_d = StErr;
                    else                                   state_d = StDataHi;
                end
            end
            StDataHi: if (accept) state_d = StDataLo;
            StDataLo: if (accept) state_d = StWrite;
            StWrite:  state_d = last_word ? FinishSt : StDataHi;
`ifdef LOADER_CHECKSUM_EN
            StChk:    if (accept) state_d = (byte_in_i == chk_q) ? StDone : StErr;
`else
            StChk:    state_d = StErr;
`endif
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            len_q        <= '0;
            idx_q        <= '0;
            hi_q         <= '0;
            byte_ready_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Status outputs are registered copies of what the next state implies.
            byte_ready_q <= takes_byte(state_d);
            ram_we_q     <= (state_d == StWrite);
            cpu_hold_q   <= (state_d != StDone);
            busy_q       <= is_busy(state_d);
            done_q       <= (state_d == StDone);
            err_q        <= (state_d == StErr);

            if (start) idx_q <= '0;
            if (state_q == StWrite && !last_word) idx_q <= idx_q + 1'b1;

            if (accept && state_q == StLenHi) len_q[15:8] <= byte_in_i;
            if (accept && state_q == StLenLo) len_q[7:0]  <= byte_in_i;
            if (accept && state_q == StDataHi) hi_q       <= byte_in_i;
            if (accept && state_q == StDataLo) begin
                ram_addr_q  <= idx_q[ADDR_W-1:0];
                ram_wdata_q <= {hi_q, byte_in_i};
            end
`ifdef LOADER_CHECKSUM_EN
            if (start) begin
                chk_q <= '0;
            end else if (accept && (state_q inside {StDataHi, StDataLo})) begin
                chk_q <= chk_q ^ byte_in_i;
            end
`endif
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Expected RAM writes are
// queued as words are driven and compared as ram_we pulses are observed.
// Expectations follow LOADER_CHECKSUM_EN when it is defined for the build.
module tb_prog_loader;

    localparam int unsigned AW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          load_req_i = 1'b0;
    logic [7:0]    byte_in_i = '0;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o, ram_we_o, cpu_hold_o, busy_o, done_o, err_o;
    logic [AW-1:0] ram_addr_o;
    logic [15:0]   ram_wdata_o;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    logic [7:0] sum_model;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_req_i   (load_req_i),
        .byte_in_i    (byte_in_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every observed write must match the oldest queued one.
    always @(negedge clk_i) begin
        if (rst_ni && ram_we_o) begin
            if (exp_q.size() == 0) begin
                check_eq("write_unexpected", 32'(ram_we_o), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("write_addr", 32'(ram_addr_o), 32'(e.addr));
                check_eq("write_data", 32'(ram_wdata_o), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        int n;
        @(negedge clk_i);
        if (jitter && ($urandom_range(0, 1) == 1)) begin
            byte_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
        byte_in_i    = b;
        byte_valid_i = 1'b1;
        n = 0;
        while (!byte_ready_o && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 64) check_eq("ready_timeout", 32'(byte_ready_o), 32'd1);
        else @(posedge clk_i);
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [15:0] data,
                             input bit jitter);
        send_byte(data[15:8], jitter);
        exp_q.push_back('{addr: addr, data: data});
        send_byte(data[7:0], jitter);
        sum_model = sum_model ^ data[15:8] ^ data[7:0];
    endtask

    task automatic end_stream();
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic start_load(input string tag);
        @(negedge clk_i);
        load_req_i = 1'b1;
        @(negedge clk_i);
        load_req_i = 1'b0;
        sum_model  = 8'h00;
        check_eq({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd1);
        check_eq({tag, "_ready"}, 32'(byte_ready_o), 32'd1);
        check_eq({tag, "_done_clr"}, 32'(done_o), 32'd0);
    endtask

    task automatic wait_end(input string tag, input bit exp_done);
        int n = 0;
        while (!done_o && !err_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done_o), 32'(exp_done));
        check_eq({tag, "_err"}, 32'(err_o), 32'(!exp_done));
        check_eq({tag, "_hold"}, 32'(cpu_hold_o), 32'(!exp_done));
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    endtask

    task automatic two_word_prog(input string tag, input bit jitter);
        start_load(tag);
        send_byte(8'h00, jitter);
        send_byte(8'h02, jitter);
        send_word(8'd0, 16'hA123, jitter);
        send_word(8'd1, 16'h4C05, jitter);
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum_model, jitter);
`endif
        end_stream();
        wait_end(tag, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check_eq({tag, "_we"}, 32'(ram_we_o), 32'd0);
        check_eq({tag, "_addr"}, 32'(ram_addr_o), 32'd0);
        check_eq({tag, "_wdata"}, 32'(ram_wdata_o), 32'd0);
        check_eq({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        sum_model = 8'h00;
        // Reset values, then a reset pulse in the middle of a load.
        #12;
        check_idle_outputs("rst_init");
        @(negedge clk_i);
        rst_ni = 1'b1;
        start_load("pre");
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(8'd0, 16'hA123, 1'b0);
        send_byte(8'h4C, 1'b0);
        byte_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1 check_idle_outputs("rst_mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("rst_rel");

        // Basic two-word program with byte_valid held high.
        two_word_prog("basic", 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong trailing checksum: error, CPU stays held.
        start_load("badchk");
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(8'd0, 16'hA123, 1'b0);
        send_word(8'd1, 16'h4C05, 1'b0);
        send_byte(8'h00, 1'b0);
        end_stream();
        wait_end("badchk", 1'b0);
`endif

        // Too-long program is rejected right after the header.
        start_load("toolong");
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        end_stream();
        wait_end("toolong", 1'b0);

        // Full-depth program: last write lands on the top address.
        start_load("full");
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            send_word(AW'(i), {lo, lo ^ 8'h5A}, 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum_model, 1'b0);
`endif
        end_stream();
        wait_end("full", 1'b1);

        // Same program as the basic one with a stuttering valid.
        two_word_prog("jitter", 1'b1);

        // Empty program reload after done.
        start_load("empty");
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        end_stream();
        wait_end("empty", 1'b1);

        repeat (4) @(negedge clk_i);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
